// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard
// detection and a saturating count of the bubbles inserted for load-use hazards.
module id_ex_stage #(
  parameter int unsigned X_LEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [X_LEN-1:0] id_rs1_data_i,
  input  logic [X_LEN-1:0] id_rs2_data_i,
  input  logic [X_LEN-1:0] id_imm_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic [3:0]       id_alu_op_i,
  input  logic             id_b_sel_i,
  input  logic             id_reg_we_i,
  input  logic             id_mem_read_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_reg_we_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic [X_LEN-1:0] mem_result_i,
  input  logic             wb_reg_we_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic [X_LEN-1:0] wb_result_i,
  output logic             ex_valid_o,
  output logic [X_LEN-1:0] ex_a_o,
  output logic [X_LEN-1:0] ex_b_o,
  output logic [3:0]       ex_alu_op_o,
  output logic [4:0]       ex_rd_addr_o,
  output logic             ex_reg_we_o,
  output logic             ex_mem_read_o,
  output logic [X_LEN-1:0] ex_store_data_o,
  output logic             load_use_stall_o,
  output logic [15:0]      bubble_cnt_o
);

  typedef struct packed {
    logic             valid;
    logic [X_LEN-1:0] rs1_data;
    logic [X_LEN-1:0] rs2_data;
    logic [X_LEN-1:0] imm;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [3:0]       alu_op;
    logic             b_sel;
    logic             reg_we;
    logic             mem_read;
  } ex_reg_t;

  ex_reg_t     ex_q, ex_d, id_pkt;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_use;
  logic [X_LEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = 1'b1;
    id_pkt.rs1_data = id_rs1_data_i;
    id_pkt.rs2_data = id_rs2_data_i;
    id_pkt.imm      = id_imm_i;
    id_pkt.rs1_addr = id_rs1_addr_i;
    id_pkt.rs2_addr = id_rs2_addr_i;
    id_pkt.rd_addr  = id_rd_addr_i;
    id_pkt.alu_op   = id_alu_op_i;
    id_pkt.b_sel    = id_b_sel_i;
    id_pkt.reg_we   = id_reg_we_i;
    id_pkt.mem_read = id_mem_read_i;
  end

  // rs2 only counts as a hazard source when the instruction actually reads it
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid_i &&
               ((ex_q.rd_addr == id_rs1_addr_i) ||
                (!id_b_sel_i && (ex_q.rd_addr == id_rs2_addr_i)));
  end

  assign load_use_stall_o = load_use && !flush_i;

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else if (id_valid_i) begin
      ex_d = id_pkt;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // MEM result is younger than WB, so it wins; x0 is never forwarded
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (mem_reg_we_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == ex_q.rs1_addr))
      fwd_rs1 = mem_result_i;
    else if (wb_reg_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == ex_q.rs1_addr))
      fwd_rs1 = wb_result_i;
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (mem_reg_we_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == ex_q.rs2_addr))
      fwd_rs2 = mem_result_i;
    else if (wb_reg_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == ex_q.rs2_addr))
      fwd_rs2 = wb_result_i;
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_a_o          = fwd_rs1;
  assign ex_b_o          = ex_q.b_sel ? ex_q.imm : fwd_rs2;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_reg_we_o     = ex_q.reg_we;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_store_data_o = fwd_rs2;
  assign bubble_cnt_o    = bubble_cnt_q;

endmodule
